// File: rtl/perfect_classifier_if.sv
// Go/done handshake bundle for the perfect-number classifier.
// go is sampled only while the classifier is idle; done pulses for one cycle with results.
interface perfect_classifier_if #(
   parameter int WIDTH = 8
);
   logic             go;
   logic [WIDTH-1:0] n;
   logic             busy;
   logic             done;
   logic [1:0]       class_o;
   logic [WIDTH+1:0] div_sum;
   logic [2:0]       dbg_state;

   modport master (
      output go, n,
      input  busy, done, class_o, div_sum, dbg_state
   );

   modport slave (
      input  go, n,
      output busy, done, class_o, div_sum, dbg_state
   );
endinterface

// File: rtl/perfect_classifier.sv
// Classifies N as deficient/perfect/abundant by summing proper divisors, testing each
// candidate with a restoring shift-subtract divider that takes WIDTH cycles.
module perfect_classifier #(
   parameter int WIDTH      = 8,
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic               clk,
   input  logic               clr,
   perfect_classifier_if.slave bus
);
   localparam int SW = WIDTH + 2;
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_DIV  = 3'd2,
      S_ACC  = 3'd3,
      S_DONE = 3'd4
   } state_e;

   state_e           state_q;
   logic [WIDTH-1:0] n_q, i_q, dvd_q, rem_q;
   logic [CW-1:0]    cnt_q;
   logic [SW-1:0]    sum_q, div_sum_q;
   logic [1:0]       class_q;
   logic             busy_q, done_q;

   logic [WIDTH:0]   shifted, trial;
   logic [WIDTH-1:0] rem_d;
   logic [SW:0]      sum_ext;
   logic [SW-1:0]    sum_d, n_ext;
   logic [1:0]       class_d;
   logic             finish_acc;

   // One restoring-division step: bring in the next dividend bit, subtract if it fits.
   assign shifted = {rem_q, dvd_q[WIDTH-1]};
   assign trial   = shifted - {1'b0, i_q};
   assign rem_d   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];

   assign n_ext   = SW'(n_q);
   assign sum_ext = {1'b0, sum_q} + (SW+1)'(i_q);

   always_comb begin
      sum_d = sum_q;
      if (rem_q == '0) begin
         sum_d = sum_ext[SW] ? '1 : sum_ext[SW-1:0];
      end
      class_d = 2'b00;
      if (sum_d > n_ext) begin
         class_d = 2'b10;
      end else if (sum_d == n_ext) begin
         class_d = 2'b01;
      end
   end

   assign finish_acc = (EARLY_EXIT && (sum_d > n_ext)) || (i_q == (n_q >> 1));

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q   <= S_IDLE;
         n_q       <= '0;
         i_q       <= '0;
         dvd_q     <= '0;
         rem_q     <= '0;
         cnt_q     <= '0;
         sum_q     <= '0;
         div_sum_q <= '0;
         class_q   <= 2'b00;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.go) begin
                  n_q       <= bus.n;
                  busy_q    <= 1'b1;
                  class_q   <= 2'b00;
                  div_sum_q <= '0;
                  state_q   <= S_LOAD;
               end
            end
            S_LOAD: begin
               i_q   <= WIDTH'(1);
               sum_q <= '0;
               dvd_q <= n_q;
               rem_q <= '0;
               cnt_q <= '0;
               if (n_q < WIDTH'(2)) begin
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  class_q   <= 2'b00;
                  div_sum_q <= '0;
                  state_q   <= S_DONE;
               end else begin
                  state_q <= S_DIV;
               end
            end
            S_DIV: begin
               dvd_q <= dvd_q << 1;
               rem_q <= rem_d;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH - 1)) begin
                  state_q <= S_ACC;
               end
            end
            S_ACC: begin
               sum_q <= sum_d;
               if (finish_acc) begin
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  class_q   <= class_d;
                  div_sum_q <= sum_d;
                  state_q   <= S_DONE;
               end else begin
                  i_q     <= i_q + WIDTH'(1);
                  dvd_q   <= n_q;
                  rem_q   <= '0;
                  cnt_q   <= '0;
                  state_q <= S_DIV;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.class_o   = class_q;
   assign bus.div_sum   = div_sum_q;
   assign bus.dbg_state = state_q;
endmodule
